// File: rtl/al_accel_pkg.sv
// rtl/al_accel_pkg.sv - shared constants and FSM encodings for the accelerator read-data fetch path
package al_accel_pkg;

    // Layer-type codes understood by the compute controller
    localparam logic [1:0] CONV  = 2'd0;
    localparam logic [1:0] DENSE = 2'd1;
    localparam logic [1:0] POOL  = 2'd2;

    // A 3x3 convolution window is the common tile shape
    localparam int unsigned DEFAULT_TILE_WORDS = 9;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_RDY  = 3'd3,
        ST_HOLD = 3'd4,
        ST_DONE = 3'd5
    } rdata_state_e;

endpackage

// File: rtl/al_accel_rdata_addr_gen.sv
// rtl/al_accel_rdata_addr_gen.sv - byte address generation for tile word reads and tile output slots
module al_accel_rdata_addr_gen #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned TILE_WORDS = 9
) (
    input  logic [15:0]       tile_i,
    input  logic [3:0]        word_i,
    input  logic [ADDR_W-1:0] in_base_i,
    input  logic [ADDR_W-1:0] out_base_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [ADDR_W-1:0] o_addr_o
);

    // Linear word index within the input tensor; all sums wrap at ADDR_W bits
    logic [ADDR_W-1:0] word_lin;

    assign word_lin   = ADDR_W'(tile_i) * ADDR_W'(TILE_WORDS) + ADDR_W'(word_i);
    assign mem_addr_o = in_base_i + (word_lin << 2);
    assign o_addr_o   = out_base_i + (ADDR_W'(tile_i) << 2);

endmodule

// File: rtl/al_accel_rdata_fetch.sv
// rtl/al_accel_rdata_fetch.sv - tile read fetcher; AL_ACCEL_RDATA_PERF_EN adds a HOLD-cycle counter
module al_accel_rdata_fetch
    import al_accel_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned TILE_WORDS = DEFAULT_TILE_WORDS
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              enb,
    input  logic              start,
    input  logic [ADDR_W-1:0] cfg_in_base,
    input  logic [ADDR_W-1:0] cfg_out_base,
    input  logic [15:0]       cfg_tile_cnt,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              tile_wr_en,
    output logic [3:0]        tile_wr_idx,
    output logic [DATA_W-1:0] tile_wr_data,
    input  logic              comps_ack,
    output logic              RDATA_rdy,
    output logic              RDATA_fin,
    output logic              RDATA_out_is_fin,
    output logic [ADDR_W-1:0] RDATA_o_addr
`ifdef AL_ACCEL_RDATA_PERF_EN
    ,
    output logic [31:0]       perf_hold_cnt
`endif
);

    rdata_state_e      state_q;
    logic [ADDR_W-1:0] in_base_q;
    logic [ADDR_W-1:0] out_base_q;
    logic [15:0]       cnt_q;
    logic [15:0]       tile_q;
    logic [3:0]        word_q;
    logic              last_word;
    logic              last_tile;
    logic              job_start;

    assign last_word = (word_q == 4'(TILE_WORDS - 1));
    assign last_tile = ((tile_q + 16'd1) == cnt_q);
    assign job_start = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && start && enb;

    // Job sequencing: one outstanding read at a time, then hand the tile downstream
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            in_base_q  <= '0;
            out_base_q <= '0;
            cnt_q      <= '0;
            tile_q     <= '0;
            word_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (job_start) begin
                        in_base_q  <= cfg_in_base;
                        out_base_q <= cfg_out_base;
                        cnt_q      <= cfg_tile_cnt;
                        tile_q     <= '0;
                        word_q     <= '0;
                        state_q    <= (cfg_tile_cnt == 16'd0) ? ST_DONE : ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (enb && mem_gnt) begin
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (mem_rvalid) begin
                        if (last_word) begin
                            state_q <= ST_RDY;
                        end else begin
                            word_q  <= word_q + 4'd1;
                            state_q <= ST_REQ;
                        end
                    end
                end
                ST_RDY, ST_HOLD: begin
                    if (comps_ack) begin
                        if (last_tile) begin
                            state_q <= ST_DONE;
                        end else begin
                            tile_q  <= tile_q + 16'd1;
                            word_q  <= '0;
                            state_q <= ST_REQ;
                        end
                    end else begin
                        state_q <= ST_HOLD;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef AL_ACCEL_RDATA_PERF_EN
    logic [31:0] perf_q;

    // Saturating count of cycles spent waiting for the compute side to take a tile
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            perf_q <= '0;
        end else if (job_start) begin
            perf_q <= '0;
        end else if ((state_q == ST_HOLD) && (perf_q != 32'hFFFF_FFFF)) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_hold_cnt = perf_q;
`endif

    al_accel_rdata_addr_gen #(
        .ADDR_W     (ADDR_W),
        .TILE_WORDS (TILE_WORDS)
    ) u_addr_gen (
        .tile_i     (tile_q),
        .word_i     (word_q),
        .in_base_i  (in_base_q),
        .out_base_i (out_base_q),
        .mem_addr_o (mem_addr),
        .o_addr_o   (RDATA_o_addr)
    );

    // Read data goes straight into the tile buffer; gated so idle outputs read as zero
    assign mem_req          = (state_q == ST_REQ) && enb;
    assign tile_wr_en       = (state_q == ST_WAIT) && mem_rvalid;
    assign tile_wr_idx      = tile_wr_en ? word_q : 4'd0;
    assign tile_wr_data     = tile_wr_en ? mem_rdata : '0;
    assign RDATA_rdy        = (state_q == ST_RDY);
    assign RDATA_fin        = (state_q == ST_DONE);
    assign RDATA_out_is_fin = ((state_q == ST_RDY) || (state_q == ST_HOLD)) && last_tile;

endmodule

// File: tb/tb_al_accel_rdata_fetch.sv
// tb/tb_al_accel_rdata_fetch.sv - directed self-checking bench for al_accel_rdata_fetch
module tb_al_accel_rdata_fetch;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              resetn = 1'b1;
    logic              enb;
    logic              start;
    logic [ADDR_W-1:0] cfg_in_base;
    logic [ADDR_W-1:0] cfg_out_base;
    logic [15:0]       cfg_tile_cnt;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_gnt;
    logic              mem_rvalid = 1'b0;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              tile_wr_en;
    logic [3:0]        tile_wr_idx;
    logic [DATA_W-1:0] tile_wr_data;
    logic              comps_ack;
    logic              RDATA_rdy;
    logic              RDATA_fin;
    logic              RDATA_out_is_fin;
    logic [ADDR_W-1:0] RDATA_o_addr;
`ifdef AL_ACCEL_RDATA_PERF_EN
    logic [31:0]       perf_hold_cnt;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    logic gnt_en = 1'b0;
    logic auto_ack = 1'b0;
    logic req_taken = 1'b0;
    logic [ADDR_W-1:0] taken_addr = '0;
    int req_cycles = 0;

    logic [ADDR_W-1:0] rd_addr_q[$];
    logic [3:0]        wr_idx_q[$];
    logic [DATA_W-1:0] wr_data_q[$];
    logic [ADDR_W-1:0] rdy_oaddr_q[$];
    logic              rdy_fin_q[$];

    always #5 clk = ~clk;

    assign mem_gnt = gnt_en & mem_req;

    al_accel_rdata_fetch dut (
        .clk              (clk),
        .resetn           (resetn),
        .enb              (enb),
        .start            (start),
        .cfg_in_base      (cfg_in_base),
        .cfg_out_base     (cfg_out_base),
        .cfg_tile_cnt     (cfg_tile_cnt),
        .mem_req          (mem_req),
        .mem_addr         (mem_addr),
        .mem_gnt          (mem_gnt),
        .mem_rvalid       (mem_rvalid),
        .mem_rdata        (mem_rdata),
        .tile_wr_en       (tile_wr_en),
        .tile_wr_idx      (tile_wr_idx),
        .tile_wr_data     (tile_wr_data),
        .comps_ack        (comps_ack),
        .RDATA_rdy        (RDATA_rdy),
        .RDATA_fin        (RDATA_fin),
        .RDATA_out_is_fin (RDATA_out_is_fin),
        .RDATA_o_addr     (RDATA_o_addr)
`ifdef AL_ACCEL_RDATA_PERF_EN
        ,
        .perf_hold_cnt    (perf_hold_cnt)
`endif
    );

    function automatic logic [DATA_W-1:0] rdata_of(input logic [ADDR_W-1:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    // Monitor: sample the DUT mid-cycle and log granted reads, tile writes, ready pulses
    always @(negedge clk) begin
        req_taken  = resetn && mem_req && mem_gnt;
        taken_addr = mem_addr;
        if (resetn) begin
            if (mem_req) req_cycles++;
            if (req_taken) rd_addr_q.push_back(mem_addr);
            if (tile_wr_en) begin
                wr_idx_q.push_back(tile_wr_idx);
                wr_data_q.push_back(tile_wr_data);
            end
            if (RDATA_rdy) begin
                rdy_oaddr_q.push_back(RDATA_o_addr);
                rdy_fin_q.push_back(RDATA_out_is_fin);
            end
        end
    end

    // Memory model: data returns the cycle after the grant; optional automatic ack of ready tiles
    always @(posedge clk) begin
        #1;
        mem_rvalid = req_taken && resetn;
        mem_rdata  = rdata_of(taken_addr);
        if (auto_ack) comps_ack = RDATA_rdy;
    end

    task automatic clear_logs();
        rd_addr_q.delete();
        wr_idx_q.delete();
        wr_data_q.delete();
        rdy_oaddr_q.delete();
        rdy_fin_q.delete();
        req_cycles = 0;
    endtask

    task automatic start_job(input logic [15:0] cnt, input logic [31:0] ib, input logic [31:0] ob);
        @(negedge clk);
        clear_logs();
        cfg_tile_cnt = cnt;
        cfg_in_base  = ib;
        cfg_out_base = ob;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_fin(input int limit, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            #1;
            if (RDATA_fin) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_reads(input int n, input int limit, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            #1;
            if (rd_addr_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        enb = 1'b1; start = 1'b0; comps_ack = 1'b0;
        cfg_in_base = '0; cfg_out_base = '0; cfg_tile_cnt = '0;
        gnt_en = 1'b1; auto_ack = 1'b0;
        #2 resetn = 1'b0;
        #1;
        tests_run++;
        if ({mem_req, mem_addr, tile_wr_en, tile_wr_idx, tile_wr_data, RDATA_rdy, RDATA_fin,
             RDATA_out_is_fin, RDATA_o_addr} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got req=%b addr=%h fin=%b oaddr=%h expected all zero",
                     mem_req, mem_addr, RDATA_fin, RDATA_o_addr);
        end
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        #1;
        tests_run++;
        if ({mem_req, RDATA_fin} !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_idle: got req=%b fin=%b expected 0 0", mem_req, RDATA_fin);
        end
    endtask

    task automatic test_zero();
        start_job(16'd0, 32'h1000, 32'h2000);
        #1;
        tests_run++;
        if (RDATA_fin !== 1'b1) begin
            tests_failed++;
            $display("FAIL zero_fin: got %b expected 1", RDATA_fin);
        end
        repeat (5) @(negedge clk);
        #1;
        tests_run++;
        if (req_cycles !== 0 || RDATA_fin !== 1'b1) begin
            tests_failed++;
            $display("FAIL zero_noreq: got req_cycles=%0d fin=%b expected 0 1", req_cycles, RDATA_fin);
        end
    endtask

    task automatic test_basic();
        logic ok;
        logic [31:0] e;
        auto_ack = 1'b1; gnt_en = 1'b1;
        start_job(16'd2, 32'h1000, 32'h2000);
        #1;
        tests_run++;
        if (RDATA_fin !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_fin_drop: got %b expected 0", RDATA_fin);
        end
        wait_fin(200, ok);
        tests_run++;
        if (ok !== 1'b1) begin
            tests_failed++;
            $display("FAIL basic_timeout: got fin=%b expected 1", RDATA_fin);
        end
        tests_run++;
        if (rd_addr_q.size() != 18 || wr_idx_q.size() != 18) begin
            tests_failed++;
            $display("FAIL basic_counts: got reads=%0d writes=%0d expected 18 18",
                     rd_addr_q.size(), wr_idx_q.size());
        end else begin
            for (int i = 0; i < 18; i++) begin
                e = 32'h1000 + 32'(4 * i);
                tests_run++;
                if (rd_addr_q[i] !== e || wr_idx_q[i] !== 4'(i % 9) || wr_data_q[i] !== rdata_of(e)) begin
                    tests_failed++;
                    $display("FAIL basic_word%0d: got addr=%h idx=%0d data=%h expected %h %0d %h",
                             i, rd_addr_q[i], wr_idx_q[i], wr_data_q[i], e, i % 9, rdata_of(e));
                end
            end
        end
        tests_run++;
        if (rdy_oaddr_q.size() != 2) begin
            tests_failed++;
            $display("FAIL basic_rdy_count: got %0d expected 2", rdy_oaddr_q.size());
        end else if (rdy_oaddr_q[0] !== 32'h2000 || rdy_oaddr_q[1] !== 32'h2004 ||
                     rdy_fin_q[0] !== 1'b0 || rdy_fin_q[1] !== 1'b1) begin
            tests_failed++;
            $display("FAIL basic_rdy_tiles: got %h/%b %h/%b expected 2000/0 2004/1",
                     rdy_oaddr_q[0], rdy_fin_q[0], rdy_oaddr_q[1], rdy_fin_q[1]);
        end
    endtask

    task automatic test_hold();
        logic seen;
        auto_ack = 1'b0; comps_ack = 1'b0; gnt_en = 1'b1;
        start_job(16'd1, 32'h300, 32'h700);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #1;
            if (RDATA_rdy) begin
                seen = 1'b1;
                break;
            end
        end
        tests_run++;
        if (seen !== 1'b1 || RDATA_o_addr !== 32'h700 || RDATA_out_is_fin !== 1'b1) begin
            tests_failed++;
            $display("FAIL hold_rdy: got seen=%b oaddr=%h last=%b expected 1 00000700 1",
                     seen, RDATA_o_addr, RDATA_out_is_fin);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            tests_run++;
            if ({mem_req, RDATA_rdy, RDATA_fin, RDATA_out_is_fin} !== 4'b0001 || RDATA_o_addr !== 32'h700) begin
                tests_failed++;
                $display("FAIL hold_cycle%0d: got req=%b rdy=%b fin=%b last=%b oaddr=%h expected 0 0 0 1 00000700",
                         i, mem_req, RDATA_rdy, RDATA_fin, RDATA_out_is_fin, RDATA_o_addr);
            end
            if (i == 19) comps_ack = 1'b1;
        end
        @(negedge clk);
        comps_ack = 1'b0;
        #1;
        tests_run++;
        if (RDATA_fin !== 1'b1) begin
            tests_failed++;
            $display("FAIL hold_done: got fin=%b expected 1", RDATA_fin);
        end
`ifdef AL_ACCEL_RDATA_PERF_EN
        tests_run++;
        if (perf_hold_cnt !== 32'd20) begin
            tests_failed++;
            $display("FAIL hold_perf: got %0d expected 20", perf_hold_cnt);
        end
`endif
    endtask

    task automatic test_enb();
        logic ok;
        logic [31:0] e;
        auto_ack = 1'b1; gnt_en = 1'b0;
        start_job(16'd1, 32'hFFFF_FFF8, 32'hFFFF_FFFC);
        #1;
        tests_run++;
        if (mem_req !== 1'b1 || mem_addr !== 32'hFFFF_FFF8) begin
            tests_failed++;
            $display("FAIL enb_first_req: got req=%b addr=%h expected 1 fffffff8", mem_req, mem_addr);
        end
        enb = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            tests_run++;
            if (mem_req !== 1'b0) begin
                tests_failed++;
                $display("FAIL enb_frozen%0d: got req=%b expected 0", i, mem_req);
            end
            @(negedge clk);
        end
        #1;
        enb = 1'b1;
        #1;
        tests_run++;
        if (mem_req !== 1'b1 || mem_addr !== 32'hFFFF_FFF8) begin
            tests_failed++;
            $display("FAIL enb_resume: got req=%b addr=%h expected 1 fffffff8", mem_req, mem_addr);
        end
        @(posedge clk);
        #3 gnt_en = 1'b1;
        wait_fin(200, ok);
        tests_run++;
        if (ok !== 1'b1 || rd_addr_q.size() != 9) begin
            tests_failed++;
            $display("FAIL enb_job: got fin=%b reads=%0d expected 1 9", ok, rd_addr_q.size());
        end else begin
            for (int i = 0; i < 9; i++) begin
                e = 32'hFFFF_FFF8 + 32'(4 * i);
                tests_run++;
                if (rd_addr_q[i] !== e) begin
                    tests_failed++;
                    $display("FAIL enb_wrap%0d: got %h expected %h", i, rd_addr_q[i], e);
                end
            end
            tests_run++;
            if (rd_addr_q[2] !== 32'h0 || rd_addr_q[8] !== 32'h18) begin
                tests_failed++;
                $display("FAIL enb_wrap_pts: got %h %h expected 00000000 00000018", rd_addr_q[2], rd_addr_q[8]);
            end
        end
        tests_run++;
        if (rdy_oaddr_q.size() != 1 || rdy_oaddr_q[0] !== 32'hFFFF_FFFC) begin
            tests_failed++;
            $display("FAIL enb_oaddr: got n=%0d expected 1 tile at fffffffc", rdy_oaddr_q.size());
        end
    endtask

    task automatic test_ignore();
        logic ok;
        auto_ack = 1'b1; gnt_en = 1'b1;
        start_job(16'd2, 32'h1000, 32'h2000);
        wait_reads(3, 100, ok);
        tests_run++;
        if (ok !== 1'b1) begin
            tests_failed++;
            $display("FAIL ignore_reads3: got %0d reads expected 3", rd_addr_q.size());
        end
        @(negedge clk);
        cfg_in_base = 32'h5000; cfg_tile_cnt = 16'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0; comps_ack = 1'b1;
        @(negedge clk);
        comps_ack = 1'b0; cfg_in_base = 32'h1000; cfg_tile_cnt = 16'd2;
        wait_fin(200, ok);
        tests_run++;
        if (ok !== 1'b1 || rd_addr_q.size() != 18 || rdy_oaddr_q.size() != 2) begin
            tests_failed++;
            $display("FAIL ignore_job: got fin=%b reads=%0d rdy=%0d expected 1 18 2",
                     ok, rd_addr_q.size(), rdy_oaddr_q.size());
        end else begin
            for (int i = 0; i < 18; i++) begin
                tests_run++;
                if (rd_addr_q[i] !== 32'h1000 + 32'(4 * i)) begin
                    tests_failed++;
                    $display("FAIL ignore_addr%0d: got %h expected %h", i, rd_addr_q[i], 32'h1000 + 32'(4 * i));
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic ok;
        auto_ack = 1'b1; gnt_en = 1'b1;
        start_job(16'd2, 32'h1000, 32'h2000);
        wait_reads(10, 100, ok);
        tests_run++;
        if (ok !== 1'b1) begin
            tests_failed++;
            $display("FAIL rstmid_reach: got %0d reads expected 10", rd_addr_q.size());
        end
        @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        tests_run++;
        if ({mem_req, mem_addr, tile_wr_en, tile_wr_idx, tile_wr_data, RDATA_rdy, RDATA_fin,
             RDATA_out_is_fin, RDATA_o_addr} !== '0) begin
            tests_failed++;
            $display("FAIL rstmid_outputs: got wr_en=%b addr=%h oaddr=%h expected all zero",
                     tile_wr_en, mem_addr, RDATA_o_addr);
        end
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        start_job(16'd1, 32'h1000, 32'h2000);
        wait_fin(200, ok);
        tests_run++;
        if (ok !== 1'b1 || rd_addr_q.size() != 9) begin
            tests_failed++;
            $display("FAIL rstmid_refetch: got fin=%b reads=%0d expected 1 9", ok, rd_addr_q.size());
        end else if (rd_addr_q[0] !== 32'h1000 || rd_addr_q[8] !== 32'h1020 || rdy_oaddr_q[0] !== 32'h2000) begin
            tests_failed++;
            $display("FAIL rstmid_addrs: got %h %h %h expected 00001000 00001020 00002000",
                     rd_addr_q[0], rd_addr_q[8], rdy_oaddr_q[0]);
        end
    endtask

    initial begin
        test_reset();
        test_zero();
        test_basic();
        test_hold();
        test_enb();
        test_ignore();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
